// File: rtl/bus2_arbiter.sv
// Two-requester round-robin arbiter for bus2: forwards one cache-line read or
// write to the memory controller, then returns the response or a timeout abort.
module bus2_arbiter #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int BEATS          = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [1:0][1:0]                REQ_C,
  input  logic [1:0][ADDR2_BUS_SIZE-1:0] REQ_A,
  input  logic [1:0][DATA2_BUS_SIZE-1:0] REQ_D,
  output logic [1:0]                     GNT,
  output logic [1:0]                     RSP_VALID,
  output logic [1:0]                     RSP_ERR,
  output logic [DATA2_BUS_SIZE-1:0]      RSP_D,
  output logic [1:0]                     MEM_C,
  output logic [ADDR2_BUS_SIZE-1:0]      MEM_A,
  output logic [DATA2_BUS_SIZE-1:0]      MEM_D,
  input  logic [1:0]                     MEM_C_IN,
  input  logic [DATA2_BUS_SIZE-1:0]      MEM_D_IN
);

  localparam logic [1:0] C2_NOP        = 2'b00;
  localparam logic [1:0] C2_RESPONSE   = 2'b01;
  localparam logic [1:0] C2_READ_LINE  = 2'b10;
  localparam logic [1:0] C2_WRITE_LINE = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WBURST = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RBURST = 3'd4;

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  logic [2:0]                state_r;
  logic [1:0]                cmd_r;
  logic [ADDR2_BUS_SIZE-1:0] addr_r;
  logic                      win_r;
  logic                      last_r;
  logic [BW-1:0]             beat_r;
  logic [TW-1:0]             wait_cnt_r;

  logic [1:0] pend_s;
  logic       winner_s;
  logic       is_write_s;
  logic       resp_s;
  logic       timeout_s;

  // Request decode and round-robin winner selection
  always_comb begin
    pend_s[0]  = (REQ_C[0] == C2_READ_LINE) || (REQ_C[0] == C2_WRITE_LINE);
    pend_s[1]  = (REQ_C[1] == C2_READ_LINE) || (REQ_C[1] == C2_WRITE_LINE);
    is_write_s = (cmd_r == C2_WRITE_LINE);
    resp_s     = (MEM_C_IN == C2_RESPONSE);
    timeout_s  = (wait_cnt_r == LAST_WAIT);
    if (pend_s == 2'b11) begin
      winner_s = ~last_r;
    end else if (pend_s[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Transaction FSM, latched command/address and beat/timeout counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= S_IDLE;
      cmd_r      <= C2_NOP;
      addr_r     <= '0;
      win_r      <= 1'b0;
      last_r     <= 1'b1;
      beat_r     <= '0;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (|pend_s) begin
            state_r <= S_CMD;
            cmd_r   <= REQ_C[winner_s];
            addr_r  <= REQ_A[winner_s];
            win_r   <= winner_s;
          end
        end
        S_CMD: begin
          wait_cnt_r <= '0;
          beat_r     <= BW'(1);
          if (is_write_s && (BEATS > 1)) begin
            state_r <= S_WBURST;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WBURST: begin
          if (beat_r == LAST_BEAT) begin
            state_r <= S_WAIT;
            beat_r  <= '0;
          end else begin
            beat_r <= beat_r + BW'(1);
          end
        end
        S_WAIT: begin
          // A response in the final wait cycle still wins over the abort
          if (resp_s) begin
            if (!is_write_s && (BEATS > 1)) begin
              state_r <= S_RBURST;
              beat_r  <= BW'(1);
            end else begin
              state_r <= S_IDLE;
              last_r  <= win_r;
            end
          end else if (timeout_s) begin
            state_r <= S_IDLE;
            last_r  <= win_r;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        S_RBURST: begin
          if (beat_r == LAST_BEAT) begin
            state_r <= S_IDLE;
            last_r  <= win_r;
            beat_r  <= '0;
          end else begin
            beat_r <= beat_r + BW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Bus and response outputs decoded from the current state
  always_comb begin
    GNT       = 2'b00;
    RSP_VALID = 2'b00;
    RSP_ERR   = 2'b00;
    RSP_D     = '0;
    MEM_C     = C2_NOP;
    MEM_A     = '0;
    MEM_D     = '0;
    case (state_r)
      S_CMD: begin
        GNT[win_r] = 1'b1;
        MEM_C      = cmd_r;
        MEM_A      = addr_r;
        MEM_D      = REQ_D[win_r];
      end
      S_WBURST: begin
        GNT[win_r] = 1'b1;
        MEM_A      = addr_r;
        MEM_D      = REQ_D[win_r];
      end
      S_WAIT: begin
        GNT[win_r] = 1'b1;
        if (resp_s) begin
          RSP_VALID[win_r] = 1'b1;
          if (!is_write_s) begin
            RSP_D = MEM_D_IN;
          end else begin
            RSP_D = '0;
          end
        end else if (timeout_s) begin
          RSP_ERR[win_r] = 1'b1;
        end else begin
          RSP_ERR = 2'b00;
        end
      end
      S_RBURST: begin
        GNT[win_r]       = 1'b1;
        RSP_VALID[win_r] = 1'b1;
        RSP_D            = MEM_D_IN;
      end
      default: begin
        GNT = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Directed bench for bus2_arbiter: single read/write, round-robin ties,
// WAIT timeout and reset in the middle of a write burst.
module tb_bus2_arbiter;

  logic             CLK;
  logic             RESET;
  logic [1:0][1:0]  REQ_C;
  logic [1:0][14:0] REQ_A;
  logic [1:0][15:0] REQ_D;
  logic [1:0]       GNT;
  logic [1:0]       RSP_VALID;
  logic [1:0]       RSP_ERR;
  logic [15:0]      RSP_D;
  logic [1:0]       MEM_C;
  logic [14:0]      MEM_A;
  logic [15:0]      MEM_D;
  logic [1:0]       MEM_C_IN;
  logic [15:0]      MEM_D_IN;

  int n_checks = 0;
  int n_errors = 0;

  bus2_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_C(REQ_C), .REQ_A(REQ_A), .REQ_D(REQ_D),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_D(RSP_D),
    .MEM_C(MEM_C), .MEM_A(MEM_A), .MEM_D(MEM_D),
    .MEM_C_IN(MEM_C_IN), .MEM_D_IN(MEM_D_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs are changed 1ns after the edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
    #1;
  endtask

  // Called in the first WAIT cycle: respond at once, stream 8 beats, end in IDLE
  task automatic read_burst(input int w, input logic [15:0] base);
    logic [31:0] vexp;
    vexp = 32'd1 << w;
    MEM_C_IN = 2'b01;
    MEM_D_IN = base;
    #1;
    check("rd_beat0_valid", 32'(RSP_VALID), vexp);
    check("rd_beat0_data", 32'(RSP_D), 32'(base));
    for (int k = 1; k < 8; k++) begin
      cyc();
      MEM_C_IN = 2'b00;
      MEM_D_IN = base + 16'(k);
      #1;
      check("rd_beat_valid", 32'(RSP_VALID), vexp);
      check("rd_beat_data", 32'(RSP_D), 32'(base + 16'(k)));
    end
    cyc();
    #1;
    check("rd_end_valid", 32'(RSP_VALID), 32'h0);
    check("rd_end_gnt", 32'(GNT), 32'h0);
    check("rd_end_rspd", 32'(RSP_D), 32'h0);
  endtask

  // Called in an IDLE cycle with both requesters holding READ_LINE
  task automatic tie_round(input logic [1:0] gexp);
    cyc();
    #1;
    check("tie_cmd_gnt", 32'(GNT), 32'(gexp));
    cyc();
    MEM_C_IN = 2'b01;
    #1;
    check("tie_wait_gnt", 32'(GNT), 32'(gexp));
    for (int k = 1; k < 8; k++) begin
      cyc();
      MEM_C_IN = 2'b00;
      #1;
      check("tie_rburst_gnt", 32'(GNT), 32'(gexp));
    end
    cyc();
    #1;
    check("tie_idle_gnt", 32'(GNT), 32'h0);
  endtask

  initial begin
    logic err_seen;
    RESET    = 1'b0;
    REQ_C    = '0;
    REQ_A    = '0;
    REQ_D    = '0;
    MEM_C_IN = 2'b00;
    MEM_D_IN = 16'h0;

    do_reset();
    check("rst_gnt", 32'(GNT), 32'h0);
    check("rst_memc", 32'(MEM_C), 32'h0);
    check("rst_mema", 32'(MEM_A), 32'h0);
    check("rst_memd", 32'(MEM_D), 32'h0);
    check("rst_valid", 32'(RSP_VALID), 32'h0);
    check("rst_err", 32'(RSP_ERR), 32'h0);

    // Requester 0 reads line 0x0123, memory answers on the 5th WAIT cycle
    REQ_C[0] = 2'b10;
    REQ_A[0] = 15'h0123;
    #1;
    check("rd_idle_gnt", 32'(GNT), 32'h0);
    cyc();
    REQ_C[0] = 2'b00;
    REQ_A[0] = 15'h0555;
    #1;
    check("rd_cmd_memc", 32'(MEM_C), 32'h2);
    check("rd_cmd_mema", 32'(MEM_A), 32'h0123);
    check("rd_cmd_gnt", 32'(GNT), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      check("rd_wait_valid", 32'(RSP_VALID), 32'h0);
    end
    check("rd_wait_memc", 32'(MEM_C), 32'h0);
    check("rd_wait_gnt", 32'(GNT), 32'h1);
    cyc();
    read_burst(0, 16'h1000);

    // Requester 1 writes line 0x7FFF, beats 0xA0..0xA7; early RESPONSE ignored
    REQ_C[1] = 2'b11;
    REQ_A[1] = 15'h7FFF;
    REQ_D[1] = 16'h00A0;
    cyc();
    REQ_C[1] = 2'b00;
    #1;
    check("wr_cmd_memc", 32'(MEM_C), 32'h3);
    check("wr_cmd_mema", 32'(MEM_A), 32'h7FFF);
    check("wr_cmd_memd", 32'(MEM_D), 32'h00A0);
    check("wr_cmd_gnt", 32'(GNT), 32'h2);
    for (int k = 1; k < 8; k++) begin
      cyc();
      REQ_D[1] = 16'h00A0 + 16'(k);
      MEM_C_IN = (k == 2) ? 2'b01 : 2'b00;
      #1;
      check("wr_beat_memc", 32'(MEM_C), 32'h0);
      check("wr_beat_memd", 32'(MEM_D), 32'h00A0 + 32'(k));
      check("wr_beat_valid", 32'(RSP_VALID), 32'h0);
    end
    cyc();
    MEM_C_IN = 2'b00;
    #1;
    check("wr_wait_memd", 32'(MEM_D), 32'h0);
    check("wr_wait_gnt", 32'(GNT), 32'h2);
    cyc();
    MEM_C_IN = 2'b01;
    #1;
    check("wr_resp_valid", 32'(RSP_VALID), 32'h2);
    check("wr_resp_err", 32'(RSP_ERR), 32'h0);
    cyc();
    MEM_C_IN = 2'b00;
    #1;
    check("wr_end_valid", 32'(RSP_VALID), 32'h0);
    check("wr_end_gnt", 32'(GNT), 32'h0);

    // Ties after reset alternate 0,1,0
    do_reset();
    REQ_C[0] = 2'b10;
    REQ_C[1] = 2'b10;
    tie_round(2'b01);
    tie_round(2'b10);
    tie_round(2'b01);
    REQ_C[0] = 2'b00;
    REQ_C[1] = 2'b00;

    // Requester 1 reads with no response: abort after 255 WAIT cycles
    cyc();
    REQ_C[1] = 2'b10;
    REQ_A[1] = 15'h0077;
    cyc();
    REQ_C[1] = 2'b00;
    #1;
    check("to_cmd_gnt", 32'(GNT), 32'h2);
    err_seen = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      cyc();
      #1;
      if ((RSP_ERR != 2'b00) || (RSP_VALID != 2'b00) || (GNT != 2'b10)) err_seen = 1'b1;
    end
    check("to_early_activity", 32'(err_seen), 32'h0);
    cyc();
    #1;
    check("to_err_pulse", 32'(RSP_ERR), 32'h2);
    check("to_err_valid", 32'(RSP_VALID), 32'h0);
    check("to_err_gnt", 32'(GNT), 32'h2);
    REQ_C[0] = 2'b10;
    REQ_A[0] = 15'h0042;
    cyc();
    #1;
    check("to_idle_err", 32'(RSP_ERR), 32'h0);
    check("to_idle_gnt", 32'(GNT), 32'h0);
    cyc();
    REQ_C[0] = 2'b00;
    #1;
    check("after_to_gnt", 32'(GNT), 32'h1);
    check("after_to_mema", 32'(MEM_A), 32'h0042);
    cyc();
    read_burst(0, 16'h2000);

    // Reset during write beat 3; late RESPONSE ignored; next tie goes to 0
    REQ_C[1] = 2'b11;
    REQ_A[1] = 15'h0555;
    REQ_D[1] = 16'h00B0;
    cyc();
    REQ_C[1] = 2'b00;
    #1;
    check("rw_cmd_gnt", 32'(GNT), 32'h2);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      REQ_D[1] = 16'h00B0 + 16'(k);
      #1;
    end
    check("rw_beat3_memd", 32'(MEM_D), 32'h00B3);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    MEM_C_IN = 2'b01;
    #1;
    check("rw_rst_gnt", 32'(GNT), 32'h0);
    check("rw_rst_memc", 32'(MEM_C), 32'h0);
    check("rw_rst_memd", 32'(MEM_D), 32'h0);
    check("rw_late_resp", 32'(RSP_VALID), 32'h0);
    cyc();
    MEM_C_IN = 2'b00;
    REQ_C[0] = 2'b10;
    REQ_C[1] = 2'b10;
    #1;
    check("rw_idle_valid", 32'(RSP_VALID), 32'h0);
    check("rw_idle_gnt", 32'(GNT), 32'h0);
    cyc();
    #1;
    check("rw_tie_gnt", 32'(GNT), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
